// File: rtl/sdram_port_arbiter_if.sv
// Bus bundle between the loaders / Z80 memory path, the port arbiter and the
// mock_sdram CPU-side port. The arbiter uses the slave modport; the
// environment (loaders, CPU, SDRAM model) uses the master modport.
interface sdram_port_arbiter_if #(
  parameter int AW = 23
);
  logic          clkref;
  logic          boot_wr;
  logic [AW-1:0] boot_addr;
  logic [7:0]    boot_data;
  logic          cart_wr;
  logic [AW-1:0] cart_addr;
  logic [7:0]    cart_data;
  logic          cpu_rd;
  logic          cpu_wr;
  logic [AW-1:0] cpu_addr;
  logic [7:0]    cpu_wdata;
  logic          cpu_ack;
  logic [7:0]    cpu_rdata;
  logic          sd_oe;
  logic          sd_we;
  logic [AW-1:0] sd_addr;
  logic [7:0]    sd_din;
  logic [7:0]    sd_dout;
  logic          busy;
  logic          ovf;

  modport slave (
    input  clkref, boot_wr, boot_addr, boot_data, cart_wr, cart_addr, cart_data,
    input  cpu_rd, cpu_wr, cpu_addr, cpu_wdata, sd_dout,
    output cpu_ack, cpu_rdata, sd_oe, sd_we, sd_addr, sd_din, busy, ovf
  );

  modport master (
    output clkref, boot_wr, boot_addr, boot_data, cart_wr, cart_addr, cart_data,
    output cpu_rd, cpu_wr, cpu_addr, cpu_wdata, sd_dout,
    input  cpu_ack, cpu_rdata, sd_oe, sd_we, sd_addr, sd_din, busy, ovf
  );
endinterface

// File: rtl/sdram_port_arbiter.sv
// Shares one SDRAM CPU-side port between a 4-entry loader write FIFO (fed by
// the boot and cartridge loaders) and the Z80 memory path. Each clkref slot
// goes to one of them, alternating when both are pending.
module sdram_port_arbiter #(
  parameter int AW  = 23,
  parameter int ACC = 6
) (
  input  logic                  clk,
  input  logic                  reset_n,
  sdram_port_arbiter_if.slave   bus
);
  localparam int CW = $clog2(ACC);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
  typedef struct packed {
    logic [AW-1:0] addr;
    logic [7:0]    data;
  } entry_t;

  // FIFO state
  logic [1:0] wr_ptr_reg, rd_ptr_reg;
  logic [2:0] count_reg, count_next;
  logic       ovf_reg, ovf_next;
  entry_t     slot_q [4];
  entry_t     push_entry, head_entry;
  logic       push_valid, push_accept, fifo_full, fifo_ne, pop;

  // Arbiter / access state
  state_t        state_reg, state_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic [AW-1:0] sd_addr_reg, sd_addr_next;
  logic [7:0]    sd_din_reg, sd_din_next;
  logic          sd_oe_reg, sd_oe_next;
  logic          sd_we_reg, sd_we_next;
  logic [7:0]    rdata_reg, rdata_next;
  logic          slot_cpu_reg, slot_cpu_next;
  logic          last_cpu_reg, last_cpu_next;
  logic          cpu_req, grant_fifo, grant_cpu;

  // Boot wins a same-cycle collision; the cart entry is the one dropped.
  assign push_valid  = bus.boot_wr | bus.cart_wr;
  assign push_entry  = bus.boot_wr ? entry_t'{bus.boot_addr, bus.boot_data}
                                   : entry_t'{bus.cart_addr, bus.cart_data};
  assign fifo_full   = (count_reg == 3'd4);
  assign fifo_ne     = (count_reg != 3'd0);
  assign push_accept = push_valid & (~fifo_full | pop);
  assign head_entry  = slot_q[rd_ptr_reg];
  assign count_next  = count_reg + 3'(push_accept) - 3'(pop);
  assign ovf_next    = ovf_reg | (bus.boot_wr & bus.cart_wr) | (push_valid & fifo_full & ~pop);

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_slot
      entry_t slot_reg;
      // Capture the pushed entry into the slot the write pointer selects
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) slot_reg <= '0;
        else if (push_accept && wr_ptr_reg == 2'(gi)) slot_reg <= push_entry;
      end
      assign slot_q[gi] = slot_reg;
    end
  endgenerate

  // FIFO pointers, occupancy and sticky drop flag
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      ovf_reg    <= 1'b0;
    end else begin
      if (push_accept) wr_ptr_reg <= wr_ptr_reg + 2'd1;
      if (pop)         rd_ptr_reg <= rd_ptr_reg + 2'd1;
      count_reg <= count_next;
      ovf_reg   <= ovf_next;
    end
  end

  // Only entries already present at the strobe compete; the FIFO wins when
  // both are pending and the CPU had the previous slot.
  assign cpu_req    = bus.cpu_rd | bus.cpu_wr;
  assign grant_fifo = fifo_ne & (~cpu_req | last_cpu_reg);
  assign grant_cpu  = cpu_req & ~grant_fifo;

  // Arbiter state register and registered SDRAM drive
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg    <= IDLE;
      cnt_reg      <= '0;
      sd_addr_reg  <= '0;
      sd_din_reg   <= '0;
      sd_oe_reg    <= 1'b0;
      sd_we_reg    <= 1'b0;
      rdata_reg    <= '0;
      slot_cpu_reg <= 1'b0;
      last_cpu_reg <= 1'b1;
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      sd_addr_reg  <= sd_addr_next;
      sd_din_reg   <= sd_din_next;
      sd_oe_reg    <= sd_oe_next;
      sd_we_reg    <= sd_we_next;
      rdata_reg    <= rdata_next;
      slot_cpu_reg <= slot_cpu_next;
      last_cpu_reg <= last_cpu_next;
    end
  end

  // Slot arbitration, access window timing and read-data capture
  always_comb begin
    state_next    = state_reg;
    cnt_next      = cnt_reg;
    sd_addr_next  = sd_addr_reg;
    sd_din_next   = sd_din_reg;
    sd_oe_next    = sd_oe_reg;
    sd_we_next    = sd_we_reg;
    rdata_next    = rdata_reg;
    slot_cpu_next = slot_cpu_reg;
    last_cpu_next = last_cpu_reg;
    pop           = 1'b0;
    unique case (state_reg)
      IDLE: begin
        if (bus.clkref) begin
          if (grant_fifo) begin
            pop           = 1'b1;
            sd_addr_next  = head_entry.addr;
            sd_din_next   = head_entry.data;
            sd_we_next    = 1'b1;
            sd_oe_next    = 1'b0;
            slot_cpu_next = 1'b0;
            last_cpu_next = 1'b0;
            cnt_next      = '0;
            state_next    = ACCESS;
          end else if (grant_cpu) begin
            sd_addr_next  = bus.cpu_addr;
            sd_din_next   = bus.cpu_wdata;
            sd_we_next    = bus.cpu_wr;
            sd_oe_next    = bus.cpu_rd & ~bus.cpu_wr;
            slot_cpu_next = 1'b1;
            last_cpu_next = 1'b1;
            cnt_next      = '0;
            state_next    = ACCESS;
          end
        end
      end
      ACCESS: begin
        if (cnt_reg == CW'(ACC - 1)) begin
          if (slot_cpu_reg && sd_oe_reg) rdata_next = bus.sd_dout;
          sd_oe_next = 1'b0;
          sd_we_next = 1'b0;
          state_next = DONE;
        end else begin
          cnt_next = cnt_reg + CW'(1);
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign bus.cpu_ack   = (state_reg == DONE) & slot_cpu_reg;
  assign bus.cpu_rdata = rdata_reg;
  assign bus.sd_oe     = sd_oe_reg;
  assign bus.sd_we     = sd_we_reg;
  assign bus.sd_addr   = sd_addr_reg;
  assign bus.sd_din    = sd_din_reg;
  assign bus.busy      = (state_reg != IDLE) | fifo_ne;
  assign bus.ovf       = ovf_reg;
endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Directed bench for sdram_port_arbiter. Stimulus pushes expected SDRAM
// accesses and CPU acks into queues; a monitor pops and compares whenever the
// DUT starts an access or pulses cpu_ack.
module tb_sdram_port_arbiter;
  localparam int AW  = 23;
  localparam int ACC = 6;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  sdram_port_arbiter_if #(.AW(AW)) bus ();
  sdram_port_arbiter #(.AW(AW), .ACC(ACC)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  typedef struct {
    logic          we;
    logic          oe;
    logic [AW-1:0] addr;
    logic [7:0]    din;
  } acc_t;

  acc_t       exp_acc [$];
  logic [7:0] exp_ack [$];
  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
  endtask

  function automatic acc_t mk(input logic we, input logic oe, input logic [AW-1:0] a, input logic [7:0] d);
    acc_t e;
    e.we = we; e.oe = oe; e.addr = a; e.din = d;
    return e;
  endfunction

  // Monitor: compares every access start, access length and ack
  int   cyc = 0, start_cyc = 0, run_len = 0;
  logic acc_prev = 1'b0, acc_now;
  acc_t cur;
  always @(negedge clk) begin
    cyc++;
    if (!reset_n) begin
      acc_prev = 1'b0;
      run_len  = 0;
    end else begin
      acc_now = bus.sd_we | bus.sd_oe;
      if (acc_now && !acc_prev) begin
        start_cyc = cyc;
        run_len   = 1;
        chk("access_expected", 32'(exp_acc.size() > 0), 1);
        if (exp_acc.size() > 0) begin
          cur = exp_acc.pop_front();
          $display("access we=%0d oe=%0d addr=0x%06h din=0x%02h", bus.sd_we, bus.sd_oe, bus.sd_addr, bus.sd_din);
          chk("acc_we",   32'(bus.sd_we),   32'(cur.we));
          chk("acc_oe",   32'(bus.sd_oe),   32'(cur.oe));
          chk("acc_addr", 32'(bus.sd_addr), 32'(cur.addr));
          chk("acc_din",  32'(bus.sd_din),  32'(cur.din));
        end
      end else if (acc_now) begin
        run_len++;
      end
      if (!acc_now && acc_prev) chk("acc_len", 32'(run_len), ACC);
      if (bus.cpu_ack) begin
        chk("ack_expected", 32'(exp_ack.size() > 0), 1);
        if (exp_ack.size() > 0) begin
          $display("ack rdata=0x%02h", bus.cpu_rdata);
          chk("ack_rdata", 32'(bus.cpu_rdata), 32'(exp_ack.pop_front()));
          chk("ack_latency", 32'(cyc - start_cyc), ACC);
        end
      end
      acc_prev = acc_now;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe();
    bus.clkref = 1'b1;
    step();
    bus.clkref = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!bus.busy) break;
    end
    chk(name, 32'(bus.busy), 0);
  endtask

  task automatic wait_ack(input string name);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.cpu_ack) break;
    end
    chk(name, 32'(bus.cpu_ack), 1);
  endtask

  task automatic pulse_reset();
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.clkref = 0; bus.boot_wr = 0; bus.boot_addr = '0; bus.boot_data = '0;
    bus.cart_wr = 0; bus.cart_addr = '0; bus.cart_data = '0;
    bus.cpu_rd = 0; bus.cpu_wr = 0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
    bus.sd_dout = '0;
    repeat (3) step();

    // Reset values
    chk("rst_cpu_ack",   32'(bus.cpu_ack),   0);
    chk("rst_cpu_rdata", 32'(bus.cpu_rdata), 0);
    chk("rst_sd_oe",     32'(bus.sd_oe),     0);
    chk("rst_sd_we",     32'(bus.sd_we),     0);
    chk("rst_sd_addr",   32'(bus.sd_addr),   0);
    chk("rst_sd_din",    32'(bus.sd_din),    0);
    chk("rst_busy",      32'(bus.busy),      0);
    chk("rst_ovf",       32'(bus.ovf),       0);
    reset_n = 1'b1;
    step();

    // FIFO write with no CPU traffic
    bus.cart_addr = 23'h040123; bus.cart_data = 8'hA5; bus.cart_wr = 1'b1;
    step();
    bus.cart_wr = 1'b0;
    exp_acc.push_back(mk(1'b1, 1'b0, 23'h040123, 8'hA5));
    step();
    strobe();
    wait_idle("fifo_write_idle");

    // CPU read
    bus.sd_dout = 8'h3E; bus.cpu_addr = 23'h000038; bus.cpu_wdata = 8'h00; bus.cpu_rd = 1'b1;
    exp_acc.push_back(mk(1'b0, 1'b1, 23'h000038, 8'h00));
    exp_ack.push_back(8'h3E);
    strobe();
    wait_ack("cpu_read_ack");
    step();
    bus.cpu_rd = 1'b0;
    step();
    chk("rdata_held", 32'(bus.cpu_rdata), 32'h3E);
    wait_idle("cpu_read_idle");

    // Alternation: 3 FIFO entries vs a continuous CPU read
    for (int i = 0; i < 3; i++) begin
      bus.cart_addr = 23'h010000 + 23'(i); bus.cart_data = 8'h10 + 8'(i); bus.cart_wr = 1'b1;
      step();
    end
    bus.cart_wr = 1'b0;
    bus.cpu_addr = 23'h000100; bus.cpu_wdata = 8'h00; bus.sd_dout = 8'h5A; bus.cpu_rd = 1'b1;
    exp_acc.push_back(mk(1'b1, 1'b0, 23'h010000, 8'h10));
    exp_acc.push_back(mk(1'b0, 1'b1, 23'h000100, 8'h00));
    exp_acc.push_back(mk(1'b1, 1'b0, 23'h010001, 8'h11));
    exp_acc.push_back(mk(1'b0, 1'b1, 23'h000100, 8'h00));
    exp_acc.push_back(mk(1'b1, 1'b0, 23'h010002, 8'h12));
    exp_ack.push_back(8'h5A);
    exp_ack.push_back(8'h5A);
    for (int k = 0; k < 5; k++) begin
      strobe();
      repeat (9) step();
    end
    bus.cpu_rd = 1'b0;
    wait_idle("alternation_idle");

    // Overflow: 5 pushes into an empty FIFO with no strobes
    for (int i = 0; i < 5; i++) begin
      bus.boot_addr = 23'h020000 + 23'(i); bus.boot_data = 8'h20 + 8'(i); bus.boot_wr = 1'b1;
      step();
    end
    bus.boot_wr = 1'b0;
    chk("ovf_after_5_pushes", 32'(bus.ovf), 1);
    for (int i = 0; i < 4; i++)
      exp_acc.push_back(mk(1'b1, 1'b0, 23'h020000 + 23'(i), 8'h20 + 8'(i)));
    for (int k = 0; k < 4; k++) begin
      strobe();
      repeat (9) step();
    end
    wait_idle("overflow_drain_idle");
    strobe();
    step();
    chk("no_fifth_entry", 32'(bus.busy), 0);

    // Simultaneous boot and cart pushes
    pulse_reset();
    chk("ovf_cleared_by_reset", 32'(bus.ovf), 0);
    bus.boot_addr = 23'h030000; bus.boot_data = 8'h31; bus.boot_wr = 1'b1;
    bus.cart_addr = 23'h030001; bus.cart_data = 8'h32; bus.cart_wr = 1'b1;
    step();
    bus.boot_wr = 1'b0; bus.cart_wr = 1'b0;
    chk("ovf_dual_push", 32'(bus.ovf), 1);
    exp_acc.push_back(mk(1'b1, 1'b0, 23'h030000, 8'h31));
    strobe();
    wait_idle("dual_push_idle");

    // Full FIFO: push in the same cycle as a FIFO grant
    pulse_reset();
    for (int i = 0; i < 4; i++) begin
      bus.boot_addr = 23'h050000 + 23'(i); bus.boot_data = 8'h40 + 8'(i); bus.boot_wr = 1'b1;
      step();
    end
    for (int i = 0; i < 5; i++)
      exp_acc.push_back(mk(1'b1, 1'b0, 23'h050000 + 23'(i), 8'h40 + 8'(i)));
    bus.boot_addr = 23'h050004; bus.boot_data = 8'h44; bus.boot_wr = 1'b1; bus.clkref = 1'b1;
    step();
    bus.boot_wr = 1'b0; bus.clkref = 1'b0;
    chk("ovf_full_push_pop", 32'(bus.ovf), 0);
    repeat (9) step();
    for (int k = 0; k < 4; k++) begin
      strobe();
      repeat (9) step();
    end
    wait_idle("full_push_pop_idle");

    // Reset in ACCESS cycle 3 of a CPU write
    bus.cpu_addr = 23'h001234; bus.cpu_wdata = 8'h77; bus.cpu_wr = 1'b1;
    exp_acc.push_back(mk(1'b1, 1'b0, 23'h001234, 8'h77));
    strobe();
    step();
    step();
    chk("we_before_reset", 32'(bus.sd_we), 1);
    reset_n = 1'b0;
    #1;
    chk("reset_sd_we", 32'(bus.sd_we), 0);
    chk("reset_cpu_ack", 32'(bus.cpu_ack), 0);
    chk("reset_busy", 32'(bus.busy), 0);
    step();
    reset_n = 1'b1;
    repeat (4) step();
    exp_acc.push_back(mk(1'b1, 1'b0, 23'h001234, 8'h77));
    exp_ack.push_back(8'h00);
    strobe();
    wait_ack("regrant_write_ack");
    step();
    bus.cpu_wr = 1'b0;
    wait_idle("regrant_idle");

    repeat (3) step();
    chk("acc_queue_drained", 32'(exp_acc.size()), 0);
    chk("ack_queue_drained", 32'(exp_ack.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/sdram_port_arbiter.md
# sdram_port_arbiter

Shares the single mock_sdram CPU-side port between the ROM boot loader, the Plus cartridge loader and the Z80 memory path. Loader writes are single-cycle pulses with no backpressure, so the block buffers them in a 4-entry write FIFO. Each clkref slot is granted to either that FIFO or the CPU, alternating when both are pending. The block drives the SDRAM `oe`/`we`/`addr`/`din` lines and returns a read-data/ack handshake to the CPU side.

## Interface
- `AW`, default 23: SDRAM byte address width.
- `ACC`, default 6: access window length in `clk` cycles; must be ≥2.
- `clk`  in  1  system clock (48 MHz).
- `reset_n`  in  1  asynchronous, active-low reset.
- `clkref`  in  1  slot strobe, one-cycle pulse; arbitration happens only on cycles where it is high.
- `boot_wr`  in  1  boot-loader write pulse.
- `boot_addr`  in  AW  boot-loader write address.
- `boot_data`  in  8  boot-loader write data.
- `cart_wr`  in  1  cartridge-loader write pulse.
- `cart_addr`  in  AW  cartridge-loader write address.
- `cart_data`  in  8  cartridge-loader write data.
- `cpu_rd`  in  1  CPU read request, level, held until ack.
- `cpu_wr`  in  1  CPU write request, level, held until ack.
- `cpu_addr`  in  AW  CPU address.
- `cpu_wdata`  in  8  CPU write data.
- `cpu_ack`  out  1  one-cycle completion pulse.
- `cpu_rdata`  out  8  read data; valid while `cpu_ack` is high and held afterwards.
- `sd_oe`  out  1  SDRAM read enable.
- `sd_we`  out  1  SDRAM write enable.
- `sd_addr`  out  AW  SDRAM address.
- `sd_din`  out  8  SDRAM write data.
- `sd_dout`  in  8  SDRAM read data.
- `busy`  out  1  high while the state is not IDLE or the FIFO is non-empty.
- `ovf`  out  1  sticky loader-drop flag.

## Operation
- **FIFO:** 4 entries of {addr, data}, 2-bit read/write pointers, 3-bit count.
  - A `boot_wr` or `cart_wr` pulse pushes one entry.
  - If both pulse in the same cycle, the boot entry is pushed, the cart entry is dropped, and `ovf` is set.
  - Push while full with no pop in the same cycle: entry dropped, `ovf` set.
  - Push while full with a pop in the same cycle: entry accepted, count unchanged.
  - Push into an empty FIFO during a grant cycle: not eligible for that grant.
- **States:** IDLE, ACCESS, DONE.
- **IDLE:** on a cycle with `clkref` high, the arbiter evaluates `fifo_ne` and `cpu_req = cpu_rd|cpu_wr`.
  - Both pending: grant goes to the opposite of `last_grant`.
  - Only one pending: grant goes to it.
  - Neither pending: stay in IDLE.
  - `last_grant` resets to CPU, so the FIFO wins the first contested slot.
- **Grant to FIFO:**
  - Pop the head entry.
  - Register `sd_addr`/`sd_din` from the entry and set `sd_we`=1, `sd_oe`=0.
  - Go to ACCESS.
- **Grant to CPU:**
  - Register `sd_addr`=`cpu_addr` and `sd_din`=`cpu_wdata`.
  - Set `sd_we`=`cpu_wr` and `sd_oe`=`cpu_rd & ~cpu_wr`; write takes precedence if both are set.
  - Go to ACCESS.
- **ACCESS:**
  - A counter runs ACC cycles; `sd_addr`/`sd_din`/`sd_oe`/`sd_we` are held constant throughout.
  - On the final cycle, `cpu_rdata` captures `sd_dout`, but only for a CPU read.
  - Then `sd_oe`/`sd_we` drop to 0 and the state goes to DONE.
- **DONE:** one cycle; `cpu_ack`=1 only if the slot was a CPU slot; then IDLE.
  - A `clkref` pulse arriving in DONE or ACCESS is ignored; that slot is lost.
- **CPU handshake:** the requester must deassert its request in the cycle after `cpu_ack`. Because IDLE only arbitrates on `clkref`, a request still high on the following cycle is not re-granted until the next strobe.
- **Reset:** `reset_n` low clears all state and outputs asynchronously, mid-access included. The FIFO is emptied and any in-flight loader write is lost.

## Timing
Reset values of all outputs: `cpu_ack`=0, `cpu_rdata`=0, `sd_oe`=0, `sd_we`=0, `sd_addr`=0, `sd_din`=0, `busy`=0, `ovf`=0.

- Cycle numbering: a grant on cycle T (`clkref` high) gives:
  - `sd_*` valid from T+1 through T+ACC;
  - read data sampled at the end of T+ACC;
  - `cpu_ack` high in T+ACC+1.
- CPU latency from the granting `clkref` to ack is ACC+1 cycles.
- FIFO throughput is one entry per accepted slot. The loader write interval must exceed 2 × slot period for lossless loading with the CPU active.

## Test plan
- **FIFO write, no CPU:** `cart_wr` with addr=0x040123, data=0xA5 → on the next `clkref`, `sd_we`=1 and `sd_addr`=0x040123 for exactly 6 cycles; `cpu_ack` stays 0; `busy` returns to 0 after DONE.
- **CPU read:** `cpu_rd` with addr=0x000038 and `sd_dout`=0x3E → `cpu_ack` 7 cycles after the grant, `cpu_rdata`=0x3E, `sd_oe` high for 6 cycles.
- **Alternation:** FIFO holding 3 entries plus a continuous CPU read → slot order FIFO, CPU, FIFO, CPU, FIFO.
- **Overflow:** 5 `boot_wr` pulses with no `clkref` → count=4, `ovf`=1, first four addresses emerge in push order. A simultaneous `boot_wr`+`cart_wr` into a non-full FIFO → only the boot entry is stored, `ovf`=1.
- **Full-FIFO push/pop:** FIFO full, `boot_wr` in the same cycle as a FIFO grant → entry accepted, count stays 4, `ovf` stays 0.
- **Reset mid-access:** `reset_n` low in ACCESS cycle 3 of a CPU write → `sd_we`, `cpu_ack`, `busy` go to 0 immediately; after release there is no ack, and the next `clkref` with `cpu_wr` still high re-grants the write.
